led_select_encoder: RTL and testbench
=====================================

// Module: led_select_encoder
// PURPOSE
//   Input-side counterpart of the 4-bit-number-to-one-hot LED decoder: takes ten
//   raw slide switches/buttons (one per LED position), synchronises and debounces
//   them, and encodes a stable one-hot selection back to a 4-bit index 0..9.
//   Emits a one-cycle valid pulse per new selection; flags multi-switch patterns.
//   Sits between board switch pins and the game/control logic driving the LEDs.
// PARAMETERS
//   N_SEL            10      number of select inputs (fixed at 10 for this design)
//   NUM_W            4       width of encoded index
//   DEBOUNCE_CYCLES  50000   cycles a pattern must hold unchanged to commit (1 ms @ 50 MHz); >=1
// PORTS
//   clk      in   1      system clock, single clock domain
//   rst      in   1      asynchronous, active-high reset
//   sw_raw   in   10     raw asynchronous switch inputs, bit i selects index i
//   number   out  4      encoded index of committed one-hot selection
//   valid    out  1      one-cycle pulse: number just updated to a new selection
//   active   out  1      high while committed pattern is exactly one-hot
//   error    out  1      high while committed pattern has >=2 bits set
// BEHAVIOUR
//   Reset (async assert, sync release): number=0, valid=0, active=0, error=0;
//     sync flops, candidate, stable pattern = 0; counter = 0; FSM = IDLE.
//   Sync: 2-flop synchroniser per bit -> sw_sync. No combinational path sw_raw->outputs.
//   Debounce: candidate reg + counter ($clog2(DEBOUNCE_CYCLES)+1 bits).
//     sw_sync != candidate -> candidate<=sw_sync, counter<=0 (restart, any bit glitch).
//     else counter saturates at DEBOUNCE_CYCLES-1; on the cycle it equals
//     DEBOUNCE_CYCLES-1 and candidate != stable -> commit: stable<=candidate.
//     Latency sw_raw edge -> commit: 2 (sync) + DEBOUNCE_CYCLES cycles; outputs +1.
//   Classification of committed pattern: ZERO (no bits), ONE (exactly one), MULTI.
//   FSM states IDLE / SELECTED / MULTI, transitions only on commit:
//     ->IDLE     : active=0, error=0, number holds last value, no valid.
//     ->SELECTED : number<=index of set bit, active=1, error=0, valid=1 one cycle.
//     ->MULTI    : error=1, active=0, number holds, no valid.
//     SELECTED->SELECTED (bit A to bit B committed directly): number<=B, valid pulse.
//     MULTI->SELECTED: valid pulse even if index equals held number.
//   Commit with unchanged pattern never occurs (candidate==stable suppressed): no
//     repeat valid while a switch is held.
//   valid is never high on two consecutive cycles (min DEBOUNCE_CYCLES apart).
//   Encoded index always 0..9; codes 10..15 never driven.
//   Bounce: any change inside the window restarts the count; only the final settled
//     pattern commits. Pattern held through reset commits 2+DEBOUNCE_CYCLES+1 cycles
//     after rst deasserts and produces valid then.
//   rst mid-count: counter and candidate cleared; partial debounce discarded.
// STRUCTURE
//   Shared package led_pkg: N_SEL=10, NUM_W=4, state enum {IDLE,SELECTED,MULTI},
//     DEBOUNCE_DEFAULT=50000.
//   Sub-module switch_debouncer (WIDTH, DEBOUNCE_CYCLES): synchroniser + candidate/
//     counter, outputs stable[WIDTH-1:0] and commit pulse. Top holds one-hot check,
//     priority-free encoder (loop), FSM and output registers.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   sw_raw=10'h008 held -> valid=1 for one cycle 7 cycles after edge, number=3, active=1.
//   sw_raw toggles 0x000/0x200 every 2 cycles x5 then holds 0x200 -> exactly one valid, number=9.
//   held 0x010, then 0x011 -> error=1, active=0, number stays 4, no valid; then 0x001 -> valid, number=0.
//   0x020 committed then 0x000 -> active=0, number stays 5, no valid; 0x020 again -> valid, number=5.
//   rst pulsed 3 cycles mid-debounce of 0x004 -> all outputs 0 during rst; valid, number=2 7 cycles after release.
//   Random bounce + patterns vs reference model: valid never back-to-back, number always <=9.

Source files
------------

// File: rtl/led_pkg.sv
// led_pkg: shared constants and FSM state type for the LED select encoder
package led_pkg;
    localparam int N_SEL            = 10;
    localparam int NUM_W            = 4;
    localparam int DEBOUNCE_DEFAULT = 50000;
    typedef enum logic [1:0] {IDLE, SELECTED, MULTI} state_t;
endpackage

// File: rtl/switch_debouncer.sv
// switch_debouncer: two-flop synchroniser plus whole-pattern debounce with commit pulse
module switch_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] pattern,
    output logic             commit
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [WIDTH-1:0] sync1, sync2, stable;
    logic [CW-1:0] count;
    assign commit = (sync2 == pattern) && (count == LAST) && (pattern != stable);
    // synchronise, restart the hold count on any change, commit once the pattern has settled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            pattern <= '0;
            stable  <= '0;
            count   <= '0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (sync2 != pattern) begin
                pattern <= sync2;
                count   <= '0;
            end else if (count != LAST) begin
                count <= count + 1'b1;
            end
            if (commit) stable <= pattern;
        end
    end
endmodule

// File: rtl/led_select_encoder.sv
// led_select_encoder: debounced ten-switch one-hot selection encoded to a 4-bit index
module led_select_encoder
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SEL-1:0] sw_raw,
    output logic [NUM_W-1:0] number,
    output logic             valid,
    output logic             active,
    output logic             error
);
    logic [N_SEL-1:0] pattern;
    logic [NUM_W-1:0] idx;
    logic commit, is_zero, is_one;
    state_t state, state_next;
    switch_debouncer #(.WIDTH(N_SEL), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .pattern(pattern),
        .commit(commit)
    );
    // OR together indices of set bits; only used when exactly one bit is set
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_SEL; i++) idx = pattern[i] ? (idx | NUM_W'(i)) : idx;
    end
    // classify the pattern being committed and pick the next state
    always_comb begin
        is_zero    = pattern == '0;
        is_one     = !is_zero && ((pattern & (pattern - 1'b1)) == '0);
        state_next = !commit ? state : is_zero ? IDLE : is_one ? SELECTED : MULTI;
    end
    // state register, index capture and single-cycle valid on a new one-hot commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            number <= '0;
            valid  <= 1'b0;
        end else begin
            state  <= state_next;
            valid  <= commit && is_one;
            if (commit && is_one) number <= idx;
        end
    end
    assign active = state == SELECTED;
    assign error  = state == MULTI;
endmodule

// File: tb/tb_led_select_encoder.sv
// tb_led_select_encoder: directed and randomised checks of the debounced selection encoder
module tb_led_select_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [9:0] sw_raw = '0;
    logic [3:0] number;
    logic valid, active, error;
    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    logic pv = 1'b0;

    led_select_encoder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .number(number),
        .valid(valid),
        .active(active),
        .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (valid) vcnt++;
            chk("no_b2b_valid", int'(valid && pv), 0);
            chk("number_range", int'(number <= 4'd9), 1);
            pv = valid;
        end
    endtask

    task automatic outs(input string tag, input int v, input int n, input int a, input int e);
        chk({tag, "_valid"}, int'(valid), v);
        chk({tag, "_number"}, int'(number), n);
        chk({tag, "_active"}, int'(active), a);
        chk({tag, "_error"}, int'(error), e);
    endtask

    task automatic hold(input logic [9:0] p, input int n);
        sw_raw = p;
        vcnt = 0;
        step(n);
    endtask

    initial begin
        logic [9:0] prev, tgt;
        int exp_num, a, b;
        repeat (3) @(posedge clk);
        #1;
        outs("reset", 0, 0, 0, 0);
        rst = 1'b0;
        step(2);

        sw_raw = 10'h008;
        vcnt = 0;
        step(6);
        chk("t1_early_valid", vcnt, 0);
        step(1);
        outs("t1_commit", 1, 3, 1, 0);
        step(1);
        chk("t1_valid_drop", int'(valid), 0);
        step(6);
        chk("t1_no_repeat", vcnt, 1);

        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            sw_raw = 10'h000;
            step(2);
            sw_raw = 10'h200;
            step(2);
        end
        step(12);
        chk("t2_one_valid", vcnt, 1);
        outs("t2_final", 0, 9, 1, 0);

        hold(10'h010, 12);
        chk("t3_sel4_valid", vcnt, 1);
        outs("t3_sel4", 0, 4, 1, 0);
        hold(10'h011, 12);
        chk("t3_multi_novalid", vcnt, 0);
        outs("t3_multi", 0, 4, 0, 1);
        hold(10'h001, 12);
        chk("t3_sel0_valid", vcnt, 1);
        outs("t3_sel0", 0, 0, 1, 0);

        hold(10'h020, 12);
        chk("t4_sel5_valid", vcnt, 1);
        hold(10'h000, 12);
        chk("t4_idle_novalid", vcnt, 0);
        outs("t4_idle", 0, 5, 0, 0);
        hold(10'h020, 12);
        chk("t4_reselect_valid", vcnt, 1);
        outs("t4_reselect", 0, 5, 1, 0);

        sw_raw = 10'h004;
        step(3);
        rst = 1'b1;
        #1;
        outs("t5_in_rst", 0, 0, 0, 0);
        step(3);
        outs("t5_rst_end", 0, 0, 0, 0);
        rst = 1'b0;
        vcnt = 0;
        pv = 1'b0;
        step(6);
        chk("t5_early_valid", vcnt, 0);
        step(1);
        outs("t5_commit", 1, 2, 1, 0);
        step(4);

        prev = 10'h004;
        exp_num = 2;
        for (int it = 0; it < 25; it++) begin
            a = $urandom_range(0, 9);
            case ($urandom_range(0, 9))
                6: tgt = 10'h000;
                7, 8: begin
                    b = (a + 1 + $urandom_range(0, 8)) % 10;
                    tgt = 10'(1 << a) | 10'(1 << b);
                end
                default: tgt = 10'(1 << a);
            endcase
            vcnt = 0;
            repeat ($urandom_range(0, 3)) begin
                sw_raw = 10'($urandom);
                step(1);
            end
            sw_raw = tgt;
            step(12);
            if ($countones(tgt) == 1) begin
                chk("rnd_valid_count", vcnt, int'(tgt != prev));
                exp_num = a;
            end else begin
                chk("rnd_valid_count", vcnt, 0);
            end
            outs("rnd_state", 0, exp_num, int'($countones(tgt) == 1), int'($countones(tgt) > 1));
            prev = tgt;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
